// File: rtl/row_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// row_sequencer_pkg
// Shared parameters and types for the row sequencer slice.
//   WL          : word length of one real or imaginary element
//   CORDIC_ITER : iteration count of the downstream CORDIC rotation stage
//   seq_state_e : sequencer FSM state encoding
//   idx_width() : safe $clog2 for index widths (never returns 0)
// -----------------------------------------------------------------------------
package row_sequencer_pkg;

  localparam int WL          = 16;
  localparam int CORDIC_ITER = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_delay_line.sv
// -----------------------------------------------------------------------------
// row_delay_line
// LAT-deep shift register carrying the issue strobe, row index and last flag
// so that they line up with the output of the rotation stage. LAT >= 1.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   in_valid/idx/last   : issue strobe, issued row index, final-row flag
//   out_valid/idx/last  : the same, delayed exactly LAT cycles
// -----------------------------------------------------------------------------
module row_delay_line #(
  parameter int LAT = 2,
  parameter int IW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [IW-1:0] in_idx,
  input  logic          in_last,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic          out_last
);

  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] last_q;
  logic [IW-1:0]  idx_q [LAT];

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            vld_q[gi]  <= 1'b0;
            last_q[gi] <= 1'b0;
            idx_q[gi]  <= '0;
          end else begin
            vld_q[gi]  <= in_valid;
            last_q[gi] <= in_last;
            idx_q[gi]  <= in_idx;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            vld_q[gi]  <= 1'b0;
            last_q[gi] <= 1'b0;
            idx_q[gi]  <= '0;
          end else begin
            vld_q[gi]  <= vld_q[gi-1];
            last_q[gi] <= last_q[gi-1];
            idx_q[gi]  <= idx_q[gi-1];
          end
        end
      end
    end
  endgenerate

  assign out_valid = vld_q[LAT-1];
  assign out_last  = last_q[LAT-1];
  assign out_idx   = idx_q[LAT-1];

endmodule

// File: rtl/row_sequencer.sv
// -----------------------------------------------------------------------------
// row_sequencer
// Collects the rows of one matrix (H row plus matching y element) into a
// buffer, then issues them one per cycle to a rotation stage of latency LAT,
// and reports which row emerges from that stage.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   s_valid/s_ready/s_last   : upstream row handshake, final-row marker
//   s_hx, s_hy, s_yx, s_yy   : incoming row (N elements of WL bits) and y
//   hold                     : pauses issue only
//   r_hx, r_hy, r_yx, r_yy   : row driven to the rotation stage (0 when idle)
//   o_valid, o_idx, o_last   : rotation-stage output strobe, row index, last
//   done                     : pulse in the final drain cycle
//   ovf                      : pulse after ROWS rows arrived with no s_last
// -----------------------------------------------------------------------------
module row_sequencer
  import row_sequencer_pkg::*;
#(
  parameter int N    = 8,
  parameter int ROWS = 8,
  parameter int LAT  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WL*N-1:0]             s_hx,
  input  logic [WL*N-1:0]             s_hy,
  input  logic [WL-1:0]               s_yx,
  input  logic [WL-1:0]               s_yy,
  input  logic                        s_last,
  input  logic                        hold,
  output logic [WL*N-1:0]             r_hx,
  output logic [WL*N-1:0]             r_hy,
  output logic [WL-1:0]               r_yx,
  output logic [WL-1:0]               r_yy,
  output logic                        o_valid,
  output logic [idx_width(ROWS)-1:0]  o_idx,
  output logic                        o_last,
  output logic                        done,
  output logic                        ovf
);

  localparam int IW = idx_width(ROWS);
  localparam int CW = $clog2(ROWS + 1);
  localparam int DW = idx_width(LAT);

  seq_state_e    state_q;
  logic [CW-1:0] wr_cnt_q;
  logic [CW-1:0] rd_cnt_q;
  logic [DW-1:0] drain_q;
  logic          ovf_q;

  logic          accept;
  logic          full;
  logic          issue;
  logic          issue_last;
  logic          drain_end;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  // Row buffer: plain register arrays, contents survive reset.
  logic [WL*N-1:0] hx_mem [ROWS];
  logic [WL*N-1:0] hy_mem [ROWS];
  logic [WL-1:0]   yx_mem [ROWS];
  logic [WL-1:0]   yy_mem [ROWS];

  assign s_ready    = (state_q == ST_IDLE) || (state_q == ST_FILL);
  assign accept     = s_valid && s_ready;
  // Accepting this row would fill the buffer.
  assign full       = (wr_cnt_q == CW'(ROWS - 1));
  assign issue      = (state_q == ST_ISSUE) && !hold;
  assign issue_last = issue && (rd_cnt_q == (wr_cnt_q - CW'(1)));
  assign drain_end  = (state_q == ST_DRAIN) && (drain_q == DW'(LAT - 1));
  assign wr_idx     = wr_cnt_q[IW-1:0];
  assign rd_idx     = rd_cnt_q[IW-1:0];

  assign done = drain_end;
  assign ovf  = ovf_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      hx_mem[wr_idx] <= s_hx;
      hy_mem[wr_idx] <= s_hy;
      yx_mem[wr_idx] <= s_yx;
      yy_mem[wr_idx] <= s_yy;
    end
  end

  // Row bus is forced to zero on every cycle that does not issue.
  assign r_hx = issue ? hx_mem[rd_idx] : '0;
  assign r_hy = issue ? hy_mem[rd_idx] : '0;
  assign r_yx = issue ? yx_mem[rd_idx] : '0;
  assign r_yy = issue ? yy_mem[rd_idx] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      drain_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_FILL: begin
          if (accept) begin
            wr_cnt_q <= wr_cnt_q + CW'(1);
            if (s_last || full) begin
              state_q <= ST_ISSUE;
              // A full buffer without s_last is closed as if it were last.
              ovf_q   <= !s_last;
            end else begin
              state_q <= ST_FILL;
            end
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            rd_cnt_q <= rd_cnt_q + CW'(1);
            if (issue_last) begin
              state_q <= ST_DRAIN;
              drain_q <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_end) begin
            state_q  <= ST_IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            drain_q  <= '0;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The delay line runs every cycle regardless of hold, so held cycles
  // appear as gaps in o_valid.
  row_delay_line #(
    .LAT (LAT),
    .IW  (IW)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_idx    (issue ? rd_idx : '0),
    .in_last   (issue_last),
    .out_valid (o_valid),
    .out_idx   (o_idx),
    .out_last  (o_last)
  );

endmodule

// File: tb/tb_row_sequencer.sv
module tb_row_sequencer;
  import row_sequencer_pkg::*;

  localparam int N    = 8;
  localparam int ROWS = 8;
  localparam int LAT  = 2;
  localparam int IW   = $clog2(ROWS);

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid;
  logic            s_ready;
  logic [WL*N-1:0] s_hx, s_hy;
  logic [WL-1:0]   s_yx, s_yy;
  logic            s_last;
  logic            hold;
  logic [WL*N-1:0] r_hx, r_hy;
  logic [WL-1:0]   r_yx, r_yy;
  logic            o_valid;
  logic [IW-1:0]   o_idx;
  logic            o_last;
  logic            done;
  logic            ovf;

  int    n_vec = 0;
  int    n_err = 0;
  string step_tag = "";

  always #5 clk = ~clk;

  row_sequencer #(.N(N), .ROWS(ROWS), .LAT(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_hx    (s_hx),
    .s_hy    (s_hy),
    .s_yx    (s_yx),
    .s_yy    (s_yy),
    .s_last  (s_last),
    .hold    (hold),
    .r_hx    (r_hx),
    .r_hy    (r_hy),
    .r_yx    (r_yx),
    .r_yy    (r_yy),
    .o_valid (o_valid),
    .o_idx   (o_idx),
    .o_last  (o_last),
    .done    (done),
    .ovf     (ovf)
  );

  // Row contents are a function of a tag so each issued row is identifiable.
  function automatic logic [WL*N-1:0] pat_hx(input int k);
    logic [WL*N-1:0] v;
    for (int i = 0; i < N; i++) v[WL*i +: WL] = WL'(k * 16 + i);
    return v;
  endfunction

  function automatic logic [WL*N-1:0] pat_hy(input int k);
    logic [WL*N-1:0] v;
    for (int i = 0; i < N; i++) v[WL*i +: WL] = WL'(32768 + k * 16 + i);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step_tag, tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance.
  // row_in / e_iss / e_oidx < 0 mean "none".
  task automatic cyc(input string tag, input bit sv, input int row_in, input bit sl,
                     input bit hd, input bit e_rdy, input int e_iss, input int e_oidx,
                     input bit e_olast, input bit e_done, input bit e_ovf);
    step_tag = tag;
    s_valid  = sv;
    s_hx     = (row_in >= 0) ? pat_hx(row_in) : '0;
    s_hy     = (row_in >= 0) ? pat_hy(row_in) : '0;
    s_yx     = (row_in >= 0) ? WL'(4096 + row_in) : '0;
    s_yy     = (row_in >= 0) ? WL'(8192 + row_in) : '0;
    s_last   = sl;
    hold     = hd;
    #1;
    chk("s_ready", 256'(s_ready), 256'(e_rdy));
    chk("r_hx", 256'(r_hx), (e_iss >= 0) ? 256'(pat_hx(e_iss)) : 256'(0));
    chk("r_hy", 256'(r_hy), (e_iss >= 0) ? 256'(pat_hy(e_iss)) : 256'(0));
    chk("r_yx", 256'(r_yx), (e_iss >= 0) ? 256'(4096 + e_iss) : 256'(0));
    chk("r_yy", 256'(r_yy), (e_iss >= 0) ? 256'(8192 + e_iss) : 256'(0));
    chk("o_valid", 256'(o_valid), 256'(e_oidx >= 0));
    if (e_oidx >= 0) chk("o_idx", 256'(o_idx), 256'(e_oidx));
    chk("o_last", 256'(o_last), 256'(e_olast));
    chk("done", 256'(done), 256'(e_done));
    chk("ovf", 256'(ovf), 256'(e_ovf));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; hold = 1'b0;
    s_hx = '0; s_hy = '0; s_yx = '0; s_yy = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    cyc("rst", 0, -1, 0, 0, 1, -1, -1, 0, 0, 0);
    rst = 1'b1;

    // Four rows, s_last on row 3
    for (int k = 0; k < 4; k++) cyc("t1_fill", 1, k, (k == 3), 0, 1, -1, -1, 0, 0, 0);
    cyc("t1_c4", 0, -1, 0, 0, 0, 0, -1, 0, 0, 0);
    cyc("t1_c5", 0, -1, 0, 0, 0, 1, -1, 0, 0, 0);
    cyc("t1_c6", 0, -1, 0, 0, 0, 2, 0, 0, 0, 0);
    cyc("t1_c7", 0, -1, 0, 0, 0, 3, 1, 0, 0, 0);
    cyc("t1_c8", 0, -1, 0, 0, 0, -1, 2, 0, 0, 0);
    cyc("t1_c9", 0, -1, 0, 0, 0, -1, 3, 1, 1, 0);
    cyc("t1_idle", 0, -1, 0, 0, 1, -1, -1, 0, 0, 0);

    // Eight rows without s_last: overflow closes the matrix
    for (int k = 0; k < 8; k++) cyc("t2_fill", 1, 20 + k, 0, 0, 1, -1, -1, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      cyc("t2_issue", 0, -1, 0, 0, 0, 20 + k, (k >= 2) ? k - 2 : -1, 0, 0, (k == 0));
    cyc("t2_d0", 0, -1, 0, 0, 0, -1, 6, 0, 0, 0);
    cyc("t2_d1", 0, -1, 0, 0, 0, -1, 7, 1, 1, 0);
    cyc("t2_idle", 0, -1, 0, 0, 1, -1, -1, 0, 0, 0);

    // Hold for 3 cycles after the second issue; s_valid kept high while busy
    for (int k = 0; k < 4; k++) cyc("t3_fill", 1, 30 + k, (k == 3), 0, 1, -1, -1, 0, 0, 0);
    cyc("t3_c4", 1, 99, 1, 0, 0, 30, -1, 0, 0, 0);
    cyc("t3_c5", 1, 99, 1, 0, 0, 31, -1, 0, 0, 0);
    cyc("t3_h0", 1, 99, 1, 1, 0, -1, 0, 0, 0, 0);
    cyc("t3_h1", 1, 99, 1, 1, 0, -1, 1, 0, 0, 0);
    cyc("t3_h2", 1, 99, 1, 1, 0, -1, -1, 0, 0, 0);
    cyc("t3_c9", 1, 99, 1, 0, 0, 32, -1, 0, 0, 0);
    cyc("t3_c10", 1, 99, 1, 0, 0, 33, -1, 0, 0, 0);
    cyc("t3_c11", 1, 99, 1, 0, 0, -1, 2, 0, 0, 0);
    cyc("t3_c12", 1, 99, 1, 0, 0, -1, 3, 1, 1, 0);
    // Next matrix (single row) accepted only after done
    cyc("t3_acc", 1, 99, 1, 0, 1, -1, -1, 0, 0, 0);
    cyc("t3_iss", 0, -1, 0, 0, 0, 99, -1, 0, 0, 0);
    cyc("t3_d0", 0, -1, 0, 0, 0, -1, -1, 0, 0, 0);
    cyc("t3_d1", 0, -1, 0, 0, 0, -1, 0, 1, 1, 0);
    cyc("t3_idle", 0, -1, 0, 0, 1, -1, -1, 0, 0, 0);

    // Reset asserted in the final DRAIN cycle
    cyc("t4_acc", 1, 40, 1, 0, 1, -1, -1, 0, 0, 0);
    cyc("t4_iss", 0, -1, 0, 0, 0, 40, -1, 0, 0, 0);
    cyc("t4_d0", 0, -1, 0, 0, 0, -1, -1, 0, 0, 0);
    step_tag = "t4_rst";
    rst = 1'b0;
    #1;
    chk("s_ready", 256'(s_ready), 256'(1));
    chk("o_valid", 256'(o_valid), 256'(0));
    chk("o_last", 256'(o_last), 256'(0));
    chk("done", 256'(done), 256'(0));
    chk("r_hx", 256'(r_hx), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc("t4_post", 0, -1, 0, 0, 1, -1, -1, 0, 0, 0);
    cyc("t4_post2", 0, -1, 0, 0, 1, -1, -1, 0, 0, 0);

    // Single row after reset: counters restart at 0
    cyc("t5_acc", 1, 50, 1, 0, 1, -1, -1, 0, 0, 0);
    cyc("t5_iss", 0, -1, 0, 0, 0, 50, -1, 0, 0, 0);
    cyc("t5_d0", 0, -1, 0, 0, 0, -1, -1, 0, 0, 0);
    cyc("t5_d1", 0, -1, 0, 0, 0, -1, 0, 1, 1, 0);
    cyc("t5_idle", 0, -1, 0, 0, 1, -1, -1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/row_sequencer.md
ROW_SEQUENCER -- requirements
Module: row_sequencer

Interface
REQ-001 Parameter N, default 8, elements per row (matches downstream rotation stage width).
REQ-002 Parameter ROWS, default 8, maximum rows per matrix held in the buffer.
REQ-003 Parameter LAT, default 2, register latency of the downstream rotation stage in cycles.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 s_valid  in  1  upstream row valid.
REQ-007 s_ready  out  1  sequencer accepts a row this cycle.
REQ-008 s_hx, s_hy  in  WL*N each  row of H, real/imag parts, element i at bits [WL*i+WL-1:WL*i].
REQ-009 s_yx, s_yy  in  WL each  matching y element.
REQ-010 s_last  in  1  marks final row of a matrix.
REQ-011 hold  in  1  pauses row issue; in-flight rows still complete.
REQ-012 r_hx, r_hy  out  WL*N each; r_yx, r_yy  out  WL each: row driven to the rotation stage.
REQ-013 o_valid  out  1  rotation-stage output valid this cycle.
REQ-014 o_idx  out  $clog2(ROWS)  row index belonging to o_valid.
REQ-015 o_last  out  1  o_valid row is the matrix's final row.
REQ-016 done  out  1  one-cycle pulse, matrix fully processed.
REQ-017 ovf  out  1  one-cycle pulse, ROWS rows received without s_last.

Function
REQ-018 States IDLE, FILL, ISSUE, DRAIN; reset state IDLE.
REQ-019 s_ready SHALL be 1 in IDLE and FILL, 0 in ISSUE and DRAIN.
REQ-020 A row is accepted when s_valid and s_ready are both 1; it is written to buffer slot wr_cnt, wr_cnt increments.
REQ-021 IDLE->FILL on accepted row without s_last; IDLE or FILL->ISSUE on accepted row with s_last.
REQ-022 Acceptance of the ROWS-th row without s_last SHALL force ->ISSUE, treat that row as last, and pulse ovf in the following cycle.
REQ-023 In ISSUE with hold=0, one row per cycle is issued in order 0..wr_cnt-1 onto r_*; with hold=1 no issue and r_* are 0.
REQ-024 r_* SHALL be 0 whenever no row is issued (IDLE, FILL, DRAIN, held cycles).
REQ-025 After issuing row wr_cnt-1: ISSUE->DRAIN; DRAIN lasts exactly LAT cycles, then ->IDLE with done=1 in the final DRAIN cycle; wr_cnt and rd_cnt cleared.
REQ-026 o_valid, o_idx, o_last SHALL be the issue strobe, index and last flag delayed exactly LAT cycles by a shift register, aligned with the rotation-stage output.
REQ-027 hold SHALL affect only issue; the delay shift register always advances.
REQ-028 Counters are $clog2(ROWS+1) bits; no wrap occurs because REQ-022 bounds wr_cnt at ROWS.
REQ-029 s_valid with s_ready=0 SHALL leave state and buffer unchanged.

Reset
REQ-030 rst=0 SHALL asynchronously force IDLE, counters 0, shift register 0, all outputs 0 except s_ready=1; buffer contents need not be cleared.
REQ-031 Reset mid-ISSUE or mid-DRAIN SHALL discard the matrix; no done pulse is produced.

Structure
REQ-032 WL and CORDIC_iter come from the shared parameters.v; the state encoding belongs in the same shared include.
REQ-033 One sub-module, row_delay_line (LAT-deep valid/idx/last shift register), is natural; the buffer is an inferred register array.

Verification
REQ-034 Four rows, s_last on row 3, hold=0 -> issue in 4 consecutive cycles, o_valid high 4 cycles starting 2 cycles after first issue, o_idx 0,1,2,3, o_last with idx 3, done 2 cycles after last issue.
REQ-035 Eight rows, no s_last -> ovf pulse, ISSUE entered, o_last on idx 7.
REQ-036 hold=1 for 3 cycles after the second issue -> r_* zero during hold, o_valid gap of 3 cycles, idx order preserved.
REQ-037 s_valid held high during ISSUE -> s_ready=0, no buffer write, next matrix accepted after done.
REQ-038 rst pulsed low during DRAIN -> all outputs 0 immediately, no done, s_ready=1.
REQ-039 Single row with s_last -> ISSUE next cycle, one o_valid with o_idx=0, o_last=1, done LAT cycles after issue.
